instruction_fetch: RTL

- Instruction Fetch (IF) stage of the pipelined RISC; sits directly upstream of the decode/operand-fetch stage.
- Owns the program counter and fetches instruction words from instruction memory over a request/acknowledge handshake.
- Presents IR and PC_M1 (PC+1) to decode with a valid flag.
- Honours a downstream stall and redirects on a taken branch/jump, flushing wrong-path work.

---
 rtl/instruction_fetch.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over REQ/ACK and hands IR/PC_M1 to decode.
// Latency: first IF_VALID two cycles after reset release with zero-wait memory; one instruction per cycle.
// Backpressure: STALL holds the output slot; a word returning under stall parks in a one-entry skid.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IR,
    output logic [31:0] PC_M1,
    output logic        IF_VALID
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      r_state,       w_state_nxt;
    logic [31:0] r_pc,          w_pc_nxt;
    logic [31:0] r_ir,          w_ir_nxt;
    logic [31:0] r_pc_m1,       w_pc_m1_nxt;
    logic        r_valid,       w_valid_nxt;
    logic [31:0] r_skid_ir,     w_skid_ir_nxt;
    logic [31:0] r_skid_pc_m1,  w_skid_pc_m1_nxt;
    logic        r_skid_vld,    w_skid_vld_nxt;
    logic [31:0] r_drop_addr,   w_drop_addr_nxt;

    logic [31:0] w_pc_inc;
    logic        w_slot_free;
    logic        w_req;

    assign w_pc_inc    = r_pc + 32'd1;
    assign w_slot_free = !r_valid || !STALL;
    assign w_req       = (r_state == S_FETCH) || (r_state == S_DROP);

    // While draining a flushed request the old address must stay on the bus.
    assign IMEM_REQ  = w_req;
    assign IMEM_ADDR = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign IR        = r_ir;
    assign PC_M1     = r_pc_m1;
    assign IF_VALID  = r_valid;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_ir         <= NOP_IR;
            r_pc_m1      <= 32'd0;
            r_valid      <= 1'b0;
            r_skid_ir    <= NOP_IR;
            r_skid_pc_m1 <= 32'd0;
            r_skid_vld   <= 1'b0;
            r_drop_addr  <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ir         <= w_ir_nxt;
            r_pc_m1      <= w_pc_m1_nxt;
            r_valid      <= w_valid_nxt;
            r_skid_ir    <= w_skid_ir_nxt;
            r_skid_pc_m1 <= w_skid_pc_m1_nxt;
            r_skid_vld   <= w_skid_vld_nxt;
            r_drop_addr  <= w_drop_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ir_nxt         = r_ir;
        w_pc_m1_nxt      = r_pc_m1;
        w_valid_nxt      = r_valid;
        w_skid_ir_nxt    = r_skid_ir;
        w_skid_pc_m1_nxt = r_skid_pc_m1;
        w_skid_vld_nxt   = r_skid_vld;
        w_drop_addr_nxt  = r_drop_addr;

        // Decode takes the slot this edge; refilled below if a word is ready.
        if (r_valid && !STALL) begin
            w_valid_nxt = 1'b0;
            w_ir_nxt    = NOP_IR;
        end

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (IMEM_ACK) begin
                    w_pc_nxt = w_pc_inc;
                    if (w_slot_free) begin
                        w_ir_nxt    = IMEM_DATA;
                        w_pc_m1_nxt = w_pc_inc;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_skid_ir_nxt    = IMEM_DATA;
                        w_skid_pc_m1_nxt = w_pc_inc;
                        w_skid_vld_nxt   = 1'b1;
                        w_state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!STALL) begin
                    if (r_skid_vld) begin
                        w_ir_nxt    = r_skid_ir;
                        w_pc_m1_nxt = r_skid_pc_m1;
                        w_valid_nxt = 1'b1;
                    end
                    w_skid_vld_nxt = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_DROP: begin
                if (IMEM_ACK) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Redirect overrides stall and any returning data.
        if (BRANCH_TAKEN) begin
            w_pc_nxt       = BRANCH_TARGET;
            w_ir_nxt       = NOP_IR;
            w_pc_m1_nxt    = r_pc_m1;
            w_valid_nxt    = 1'b0;
            w_skid_vld_nxt = 1'b0;
            if (w_req && !IMEM_ACK) begin
                w_state_nxt = S_DROP;
                if (r_state == S_FETCH) begin
                    w_drop_addr_nxt = r_pc;
                end
            end else begin
                w_state_nxt = S_FETCH;
            end
        end
    end

endmodule
